// File: rtl/majority_vote_scheduler_if.sv
// Vote/response bundle between requesters, the shared majority
// detector and the single result consumer.
interface majority_vote_scheduler_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_BITS  = 2,
    parameter int CNT_BITS = 8
);
    logic [NUM_REQ-1:0]   req_val;
    logic [NUM_REQ-1:0]   req_rdy;
    logic [3*NUM_REQ-1:0] req_bits;
    logic                 resp_val;
    logic                 resp_rdy;
    logic                 resp_out;
    logic [ID_BITS-1:0]   resp_id;
    logic                 cnt_clr;
    logic [CNT_BITS-1:0]  hit_count;

    modport master (
        output req_val, req_bits, resp_rdy, cnt_clr,
        input  req_rdy, resp_val, resp_out, resp_id, hit_count
    );

    modport slave (
        input  req_val, req_bits, resp_rdy, cnt_clr,
        output req_rdy, resp_val, resp_out, resp_id, hit_count
    );
endinterface

// File: rtl/majority_vote_scheduler.sv
// Round-robin sharing of one 2-of-3 majority detector with a
// one-entry response buffer and a saturating hit counter.
module majority_vote_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int ID_BITS  = 2,
    parameter int CNT_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    majority_vote_scheduler_if.slave      bus
);
    typedef enum logic {EMPTY, FULL} state_e;

    state_e              state_q, state_d;
    logic                resp_out_q, resp_out_d;
    logic [ID_BITS-1:0]  resp_id_q, resp_id_d;
    logic [ID_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_BITS-1:0] hit_q, hit_d;

    logic               can_acc;
    logic               gnt_any;
    logic [ID_BITS-1:0] gnt_id;
    logic               acc;
    logic [2:0]         vote;
    logic               maj;
    int                 idx;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!gnt_any && bus.req_val[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_BITS'(idx);
            end
        end
    end

    assign can_acc = (state_q == EMPTY) || bus.resp_rdy;
    assign acc     = can_acc && gnt_any && rst_n;
    assign vote    = bus.req_bits[3*int'(gnt_id) +: 3];
    assign maj     = (vote[0] & vote[1]) | ((vote[0] | vote[1]) & vote[2]);

    always_comb begin
        bus.req_rdy = '0;
        if (acc) begin
            bus.req_rdy[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        resp_out_d = resp_out_q;
        resp_id_d  = resp_id_q;
        rr_ptr_d   = rr_ptr_q;
        hit_d      = hit_q;
        if (acc) begin
            state_d    = FULL;
            resp_out_d = maj;
            resp_id_d  = gnt_id;
            rr_ptr_d   = ID_BITS'((int'(gnt_id) + 1) % NUM_REQ);
        end else if (state_q == FULL && bus.resp_rdy) begin
            state_d = EMPTY;
        end
        if (bus.cnt_clr) begin
            hit_d = '0;
        end else if (acc && maj && (hit_q != {CNT_BITS{1'b1}})) begin
            hit_d = hit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            resp_out_q <= 1'b0;
            resp_id_q  <= '0;
            rr_ptr_q   <= '0;
            hit_q      <= '0;
        end else begin
            state_q    <= state_d;
            resp_out_q <= resp_out_d;
            resp_id_q  <= resp_id_d;
            rr_ptr_q   <= rr_ptr_d;
            hit_q      <= hit_d;
        end
    end

    assign bus.resp_val  = (state_q == FULL);
    assign bus.resp_out  = resp_out_q;
    assign bus.resp_id   = resp_id_q;
    assign bus.hit_count = hit_q;
endmodule

// File: tb/tb_majority_vote_scheduler.sv
// Directed checks of arbitration, buffering, backpressure,
// counter saturation/clear and async reset.
module tb_majority_vote_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    majority_vote_scheduler_if #(
        .NUM_REQ(4), .ID_BITS(2), .CNT_BITS(2)
    ) bus ();

    majority_vote_scheduler #(
        .NUM_REQ(4), .ID_BITS(2), .CNT_BITS(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_votes(input logic [2:0] v0, input logic [2:0] v1,
                             input logic [2:0] v2, input logic [2:0] v3);
        bus.req_bits = {v3, v2, v1, v0};
    endtask

    initial begin
        int gseq [5];
        int oseq [5];
        gseq = '{0, 1, 2, 3, 0};
        oseq = '{0, 1, 1, 0, 0};

        rst_n        = 1'b0;
        bus.req_val  = 4'b1111;
        bus.req_bits = '0;
        bus.resp_rdy = 1'b0;
        bus.cnt_clr  = 1'b0;
        #1;
        chk("init_resp_val", 32'(bus.resp_val), 0);
        chk("init_hit", 32'(bus.hit_count), 0);
        chk("init_req_rdy", 32'(bus.req_rdy), 0);
        step();
        step();
        bus.req_val = 4'b0000;
        rst_n       = 1'b1;
        step();

        // T2 single vote
        bus.req_val  = 4'b0010;
        set_votes(3'b000, 3'b011, 3'b000, 3'b000);
        bus.resp_rdy = 1'b1;
        #1;
        chk("t2_req_rdy", 32'(bus.req_rdy), 32'b0010);
        step();
        chk("t2_resp_val", 32'(bus.resp_val), 1);
        chk("t2_resp_out", 32'(bus.resp_out), 1);
        chk("t2_resp_id", 32'(bus.resp_id), 1);
        chk("t2_hit", 32'(bus.hit_count), 1);

        // T1 async reset mid-run with a full buffer
        bus.req_val = 4'b1111;
        set_votes(3'b001, 3'b110, 3'b101, 3'b100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_resp_val", 32'(bus.resp_val), 0);
        chk("t1_resp_id", 32'(bus.resp_id), 0);
        chk("t1_hit", 32'(bus.hit_count), 0);
        chk("t1_req_rdy", 32'(bus.req_rdy), 0);
        step();
        chk("t1_hold_val", 32'(bus.resp_val), 0);
        rst_n = 1'b1;
        #1;

        // T3 round robin
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_rdy%0d", i), 32'(bus.req_rdy),
                32'(1) << gseq[i]);
            step();
            chk($sformatf("t3_id%0d", i), 32'(bus.resp_id), 32'(gseq[i]));
            chk($sformatf("t3_out%0d", i), 32'(bus.resp_out),
                32'(oseq[i]));
        end
        chk("t3_hit", 32'(bus.hit_count), 2);

        // T4 backpressure: load id 2 with a hit
        bus.req_val = 4'b0100;
        #1;
        chk("t4_load_rdy", 32'(bus.req_rdy), 32'b0100);
        step();
        chk("t4_load_id", 32'(bus.resp_id), 2);
        chk("t4_load_out", 32'(bus.resp_out), 1);
        chk("t4_hit", 32'(bus.hit_count), 3);
        bus.resp_rdy = 1'b0;
        bus.req_val  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4_bp_rdy%0d", i), 32'(bus.req_rdy), 0);
            step();
            chk($sformatf("t4_bp_val%0d", i), 32'(bus.resp_val), 1);
            chk($sformatf("t4_bp_id%0d", i), 32'(bus.resp_id), 2);
            chk($sformatf("t4_bp_out%0d", i), 32'(bus.resp_out), 1);
        end
        bus.resp_rdy = 1'b1;
        #1;
        chk("t4_refill_rdy", 32'(bus.req_rdy), 32'b1000);
        step();
        chk("t4_refill_val", 32'(bus.resp_val), 1);
        chk("t4_refill_id", 32'(bus.resp_id), 3);
        chk("t4_refill_out", 32'(bus.resp_out), 0);
        chk("t4_sat_hold", 32'(bus.hit_count), 3);

        // Drain with clear; rr_ptr must stay at 0
        bus.req_val = 4'b0000;
        bus.cnt_clr = 1'b1;
        step();
        chk("drain1_val", 32'(bus.resp_val), 0);
        chk("clr_hit", 32'(bus.hit_count), 0);
        bus.cnt_clr = 1'b0;
        bus.req_val = 4'b1111;
        #1;
        chk("drain1_ptr", 32'(bus.req_rdy), 32'b0001);

        // T5 saturation then clear against a same-cycle hit
        set_votes(3'b111, 3'b111, 3'b111, 3'b111);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t5_hit%0d", i), 32'(bus.hit_count),
                (i < 3) ? 32'(i + 1) : 32'd3);
        end
        bus.cnt_clr = 1'b1;
        step();
        chk("t5_clr_wins", 32'(bus.hit_count), 0);
        chk("t5_clr_id", 32'(bus.resp_id), 1);

        // T6 drain without refill
        bus.cnt_clr = 1'b0;
        bus.req_val = 4'b0000;
        step();
        chk("t6_val", 32'(bus.resp_val), 0);
        chk("t6_out_hold", 32'(bus.resp_out), 1);
        chk("t6_id_hold", 32'(bus.resp_id), 1);
        step();
        chk("t6_idle_val", 32'(bus.resp_val), 0);
        bus.req_val = 4'b1111;
        #1;
        chk("t6_ptr", 32'(bus.req_rdy), 32'b0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
